// File: rtl/move_scheduler_if.sv
// move_scheduler_if: command handshake between the move scheduler and the movement datapath.
// Latency: none, plain wires.
// Backpressure: move_ready low stalls the offered command; move_done closes the issued one.
interface move_scheduler_if;
   logic       move_valid;
   logic [1:0] move_cmd;
   logic       move_ready;
   logic       move_done;

   modport master (output move_valid, move_cmd, input move_ready, move_done);
   modport slave  (input move_valid, move_cmd, output move_ready, move_done);
endinterface

// File: rtl/move_scheduler.sv
// move_scheduler: latches fwd/bwd/rotate pulses, queues them in order, issues one move per frame.
// Latency: pulse at t -> pending t+1 -> queued t+2 -> move_valid t+3 when idle; commit the cycle after frame_switch.
// Backpressure: move_ready low holds the head; a full queue keeps requests pending; a repeat of a pending request is dropped (overflow).
// Optional: MOVE_COALESCE_EN lets a command cancel its opposite at the un-issued queue tail.
module move_scheduler #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   fwd_pulse,
   input  logic                   bwd_pulse,
   input  logic                   leftRot_pulse,
   input  logic                   rightRot_pulse,
   input  logic                   frame_switch,
   move_scheduler_if.master       mv,
   output logic                   pose_commit,
   output logic [$clog2(DEPTH):0] queue_count,
   output logic                   busy,
   output logic                   overflow,
   output logic                   timeout_err
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

   state_t        state;
   logic [3:0]    pending;
   logic [1:0]    fifo_mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [TW-1:0] timer;

   logic [3:0]    req;
   logic [3:0]    accept;
   logic [3:0]    drain_clr;
   logic          drain_vld;
   logic [1:0]    drain_cmd;
   logic          drain_go;
   logic          fifo_full;
   logic          push;
   logic          pop;
   logic          cancel;

   // Request bit index doubles as the command code: 0=fwd 1=bwd 2=left 3=right.
   assign req       = {rightRot_pulse, leftRot_pulse, bwd_pulse, fwd_pulse};
   assign accept    = req & ~pending;
   assign fifo_full = (count == CW'(DEPTH));
   assign drain_go  = drain_vld && !fifo_full;
   assign pop       = (state == ISSUE) && mv.move_valid && mv.move_ready;

   // Pick the lowest-index pending request so fwd > bwd > left > right.
   always_comb begin
      drain_vld = 1'b0;
      drain_cmd = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (pending[i]) begin
            drain_vld = 1'b1;
            drain_cmd = 2'(i);
         end
      end
   end

`ifdef MOVE_COALESCE_EN
   logic [1:0] tail_cmd;
   logic       tail_locked;

   assign tail_cmd    = fifo_mem[wr_ptr - AW'(1)];
   // A lone entry is being latched (IDLE) or offered (ISSUE) as the head, so it is no longer cancellable.
   assign tail_locked = (count == CW'(1)) && ((state == IDLE) || (state == ISSUE));
   // Opposite pairs differ only in bit 0 of the code.
   assign cancel      = drain_go && (count != '0) && !tail_locked && (tail_cmd == (drain_cmd ^ 2'd1));
`else
   assign cancel      = 1'b0;
`endif

   assign push      = drain_go && !cancel;
   assign drain_clr = drain_go ? (4'b0001 << drain_cmd) : 4'b0000;

   // Pending mask: new pulses set their bit, the drained bit clears, repeats of a set bit are flagged.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         pending  <= '0;
         overflow <= 1'b0;
      end else begin
         pending <= (pending & ~drain_clr) | accept;
         if (|(req & pending)) begin
            overflow <= 1'b1;
         end
      end
   end

   // Queue storage; validity is tracked by the pointers, so no reset is needed here.
   always_ff @(posedge clk_in) begin
      if (push) begin
         fifo_mem[wr_ptr] <= drain_cmd;
      end
   end

   // Circular pointers and exact occupancy; a cancel steps the write pointer back over the tail.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end else if (cancel) begin
            wr_ptr <= wr_ptr - AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CW'(push) - CW'(pop) - CW'(cancel);
      end
   end

   // Issue, wait for completion, then hold until the next frame boundary before committing.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state         <= IDLE;
         mv.move_valid <= 1'b0;
         mv.move_cmd   <= 2'd0;
         pose_commit   <= 1'b0;
         timer         <= '0;
         timeout_err   <= 1'b0;
      end else begin
         pose_commit <= 1'b0;
         case (state)
            IDLE: begin
               if (count != '0) begin
                  state         <= ISSUE;
                  mv.move_valid <= 1'b1;
                  mv.move_cmd   <= fifo_mem[rd_ptr];
               end
            end
            ISSUE: begin
               if (mv.move_ready) begin
                  state         <= WAIT;
                  mv.move_valid <= 1'b0;
                  timer         <= '0;
               end
            end
            WAIT: begin
               if (mv.move_done) begin
                  state <= HOLD;
               end else if (timer == TW'(TIMEOUT - 1)) begin
                  state       <= IDLE;
                  timeout_err <= 1'b1;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            HOLD: begin
               if (frame_switch) begin
                  state       <= IDLE;
                  pose_commit <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy        = (state != IDLE);
   assign queue_count = count;
endmodule

// File: tb/tb_move_scheduler.sv
// tb_move_scheduler: directed scenarios plus random bursts against a transaction-level scoreboard.
// Latency: checks cycle-exact timing in directed scenarios, ordering and commit pairing in random ones.
// Backpressure: a randomized datapath responder toggles move_ready and delays move_done.
module tb_move_scheduler;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 64;

   logic       clk_in = 1'b0;
   logic       rst_in = 1'b0;
   logic       fwd_pulse = 1'b0;
   logic       bwd_pulse = 1'b0;
   logic       leftRot_pulse = 1'b0;
   logic       rightRot_pulse = 1'b0;
   logic       frame_switch = 1'b0;
   logic       pose_commit;
   logic [2:0] queue_count;
   logic       busy;
   logic       overflow;
   logic       timeout_err;

   move_scheduler_if mif ();

   move_scheduler #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .fwd_pulse     (fwd_pulse),
      .bwd_pulse     (bwd_pulse),
      .leftRot_pulse (leftRot_pulse),
      .rightRot_pulse(rightRot_pulse),
      .frame_switch  (frame_switch),
      .mv            (mif),
      .pose_commit   (pose_commit),
      .queue_count   (queue_count),
      .busy          (busy),
      .overflow      (overflow),
      .timeout_err   (timeout_err)
   );

   always #5 clk_in = ~clk_in;

   int checks = 0;
   int errors = 0;
   int exp_q[$];
   bit mon_en = 1'b0;
   bit in_flight = 1'b0;
   bit commit_owed = 1'b0;
   bit expect_commit = 1'b0;
   int n_commits = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic pulse(input logic [3:0] m);
      {rightRot_pulse, leftRot_pulse, bwd_pulse, fwd_pulse} = m;
      tick(1);
      {rightRot_pulse, leftRot_pulse, bwd_pulse, fwd_pulse} = 4'b0000;
   endtask

   task automatic apply_reset();
      rst_in = 1'b0;
      {rightRot_pulse, leftRot_pulse, bwd_pulse, fwd_pulse} = 4'b0000;
      frame_switch   = 1'b0;
      mif.move_ready = 1'b0;
      mif.move_done  = 1'b0;
      tick(2);
      rst_in = 1'b1;
      tick(1);
   endtask

   // Reference: a burst yields its set bits in priority order, each move earns exactly one commit.
   task automatic push_exp(input logic [3:0] m);
      for (int i = 0; i < 4; i++) if (m[i]) exp_q.push_back(i);
   endtask

   function automatic bit drained();
      return (exp_q.size() == 0) && !in_flight && !commit_owed && !expect_commit &&
             !busy && (queue_count == 3'd0) && !mif.move_valid;
   endfunction

   task automatic wait_drained(input int budget);
      int n = 0;
      while (!drained() && n < budget) begin
         tick(1);
         n++;
      end
      chk("drain_within_budget", int'(drained()), 1);
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk_in);
         if (mon_en) begin
            if (expect_commit || pose_commit) begin
               chk("commit_after_frame", int'(pose_commit), int'(expect_commit));
               if (pose_commit) n_commits++;
            end
            expect_commit = 1'b0;
            if (commit_owed && frame_switch) begin
               expect_commit = 1'b1;
               commit_owed   = 1'b0;
            end
            if (in_flight && mif.move_done) begin
               commit_owed = 1'b1;
               in_flight   = 1'b0;
            end
            if (mif.move_valid && mif.move_ready) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_move: cmd %0d offered, expected none", mif.move_cmd);
               end else begin
                  int e;
                  e = exp_q.pop_front();
                  if (int'(mif.move_cmd) != e) begin
                     errors++;
                     $display("FAIL move_cmd: got %0d, expected %0d (t=%0t)", mif.move_cmd, e, $time);
                  end
               end
               chk("prev_move_closed", int'(commit_owed || expect_commit || in_flight), 0);
               in_flight = 1'b1;
            end
         end
      end
   endtask

   // Runs nb random bursts (or just drains what is queued) with a random datapath and frame clock.
   task automatic run_env(input int nb);
      bit fin;
      fin = 1'b0;
      in_flight = 1'b0; commit_owed = 1'b0; expect_commit = 1'b0;
      mon_en = 1'b1;
      fork
         begin
            for (int b = 0; b < nb; b++) begin
               logic [3:0] m;
               wait_drained(3000);
               m = 4'($urandom_range(1, 15));
`ifdef MOVE_COALESCE_EN
               if (m[0] && m[1]) m[1] = 1'b0;
               if (m[2] && m[3]) m[3] = 1'b0;
`endif
               push_exp(m);
               pulse(m);
`ifndef MOVE_COALESCE_EN
               if ($urandom_range(0, 1) == 1) begin
                  tick(4);
                  m = 4'($urandom_range(1, 15));
                  push_exp(m);
                  pulse(m);
               end
`endif
            end
            wait_drained(3000);
            fin = 1'b1;
         end
         begin
            bit hs;
            int dly = 0;
            while (!fin) begin
               @(negedge clk_in);
               hs = mif.move_valid && mif.move_ready;
               @(posedge clk_in);
               #1;
               mif.move_done = 1'b0;
               if (hs) begin
                  mif.move_ready = 1'b0;
                  dly = $urandom_range(1, 12);
               end else if (dly > 0) begin
                  dly--;
                  if (dly == 0) mif.move_done = 1'b1;
               end else begin
                  mif.move_ready = ($urandom_range(0, 3) != 0);
               end
            end
         end
         begin
            while (!fin) begin
               @(posedge clk_in);
               #1;
               frame_switch = ($urandom_range(0, 5) == 0);
            end
         end
      join
      mif.move_ready = 1'b0;
      mif.move_done  = 1'b0;
      frame_switch   = 1'b0;
      tick(1);
      mon_en = 1'b0;
   endtask

   initial begin
      int peak;
      int c0;
      fork
         monitor();
      join_none

      // Reset state
      #1;
      chk("rst_move_valid", int'(mif.move_valid), 0);
      chk("rst_pose_commit", int'(pose_commit), 0);
      chk("rst_queue_count", int'(queue_count), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_overflow", int'(overflow), 0);
      chk("rst_timeout_err", int'(timeout_err), 0);

      // Single fwd: latency, frame ignored in WAIT, commit the cycle after frame_switch
      apply_reset();
      mif.move_ready = 1'b1;
      pulse(4'b0001);
      chk("t1_valid_t1", int'(mif.move_valid), 0);
      chk("t1_count_t1", int'(queue_count), 0);
      tick(1);
      chk("t1_count_t2", int'(queue_count), 1);
      chk("t1_valid_t2", int'(mif.move_valid), 0);
      tick(1);
      chk("t1_valid_t3", int'(mif.move_valid), 1);
      chk("t1_cmd_t3", int'(mif.move_cmd), 0);
      chk("t1_busy_t3", int'(busy), 1);
      tick(1);
      chk("t1_valid_after_accept", int'(mif.move_valid), 0);
      chk("t1_count_after_pop", int'(queue_count), 0);
      frame_switch = 1'b1;
      tick(1);
      frame_switch = 1'b0;
      chk("t1_no_commit_in_wait", int'(pose_commit), 0);
      mif.move_done = 1'b1;
      tick(1);
      mif.move_done = 1'b0;
      tick(3);
      chk("t1_hold_no_commit", int'(pose_commit), 0);
      chk("t1_hold_busy", int'(busy), 1);
      frame_switch = 1'b1;
      tick(1);
      frame_switch = 1'b0;
      chk("t1_commit", int'(pose_commit), 1);
      tick(1);
      chk("t1_commit_one_cycle", int'(pose_commit), 0);
      chk("t1_idle", int'(busy), 0);

      // fwd+left+right together: order and peak occupancy, then one commit per move
      apply_reset();
      pulse(4'b1101);
      peak = 0;
      for (int i = 0; i < 6; i++) begin
         if (int'(queue_count) > peak) peak = int'(queue_count);
         tick(1);
      end
      c0 = n_commits;
`ifdef MOVE_COALESCE_EN
      chk("t2_peak", peak, 2);
      push_exp(4'b0001);
      run_env(0);
      chk("t2_commits", n_commits - c0, 1);
`else
      chk("t2_peak", peak, 3);
      push_exp(4'b1101);
      run_env(0);
      chk("t2_commits", n_commits - c0, 3);
`endif

      // Saturation: six fwd pulses with move_ready low
      apply_reset();
      for (int k = 0; k < 5; k++) begin
         pulse(4'b0001);
         tick(1);
      end
      chk("t3_overflow_before_6th", int'(overflow), 0);
      chk("t3_count_full", int'(queue_count), DEPTH);
      pulse(4'b0001);
      tick(1);
      chk("t3_overflow_after_6th", int'(overflow), 1);
      chk("t3_count_still_full", int'(queue_count), DEPTH);
      chk("t3_head_cmd", int'(mif.move_cmd), 0);
      for (int k = 0; k < 5; k++) exp_q.push_back(0);
      run_env(0);
      chk("t3_overflow_sticky", int'(overflow), 1);

      // Timeout: accepted move never completes
      apply_reset();
      mif.move_ready = 1'b1;
      pulse(4'b0001);
      tick(2);
      chk("t4_valid", int'(mif.move_valid), 1);
      tick(1);
      mif.move_ready = 1'b0;
      chk("t4_in_wait", int'(busy), 1);
      tick(TIMEOUT - 1);
      chk("t4_no_timeout_yet", int'(timeout_err), 0);
      tick(1);
      chk("t4_timeout", int'(timeout_err), 1);
      chk("t4_back_idle", int'(busy), 0);
      frame_switch = 1'b1;
      mif.move_done = 1'b1;
      tick(1);
      frame_switch = 1'b0;
      mif.move_done = 1'b0;
      chk("t4_no_commit", int'(pose_commit), 0);
      tick(1);
      chk("t4_no_commit_later", int'(pose_commit), 0);
      chk("t4_timeout_sticky", int'(timeout_err), 1);

      // Reset during WAIT with two entries queued
      apply_reset();
      mif.move_ready = 1'b1;
      pulse(4'b0111);
      tick(3);
      mif.move_ready = 1'b0;
      chk("t5_wait_count", int'(queue_count), 2);
      chk("t5_wait_busy", int'(busy), 1);
      rst_in = 1'b0;
      #1;
      chk("t5_rst_valid", int'(mif.move_valid), 0);
      chk("t5_rst_count", int'(queue_count), 0);
      chk("t5_rst_busy", int'(busy), 0);
      tick(1);
      rst_in = 1'b1;
      for (int i = 0; i < 6; i++) begin
         frame_switch  = (i % 2 == 0);
         mif.move_done = (i == 1);
         tick(1);
         chk("t5_no_commit", int'(pose_commit), 0);
      end
      frame_switch  = 1'b0;
      mif.move_done = 1'b0;
      chk("t5_stays_idle", int'(busy), 0);

      // Opposite command against an un-issued tail, head held in ISSUE
      apply_reset();
      pulse(4'b0001);
      tick(2);
      chk("t6_head_issued", int'(mif.move_valid), 1);
      pulse(4'b0001);
      tick(1);
      pulse(4'b0010);
      tick(3);
`ifdef MOVE_COALESCE_EN
      chk("t6_count", int'(queue_count), 1);
      push_exp(4'b0001);
`else
      chk("t6_count", int'(queue_count), 3);
      exp_q.push_back(0);
      exp_q.push_back(0);
      exp_q.push_back(1);
`endif
      run_env(0);

      // Random bursts
      apply_reset();
      run_env(30);
      chk("rand_no_overflow", int'(overflow), 0);
      chk("rand_no_timeout", int'(timeout_err), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL global_time_limit: simulation still running at t=%0t, expected completion", $time);
      $fatal(1);
   end
endmodule
